delay_probe: RTL and testbench
==============================

// Module: delay_probe
// PURPOSE
//  Measures the round-trip latency, in i_ce samples, of a DSP path. It drives
//   one impulse out on o_word, then counts samples until the return path
//   shows the impulse on i_return. The result programs a delay line such as
//   delayw. Between measurements, i_word passes through to o_word.
// PARAMETERS
//  LGDLY   5              log2 of the measurement span; results run 1..2^LGDLY-1
//  DW      12             word width of i_word, o_word and i_return (signed)
//  AMP     2^(DW-2)       impulse amplitude driven on o_word during the FIRE sample
//  THRESH  2^(DW-3)       detect when signed i_return >= THRESH
// PORTS
//  i_clk      in   1      clock
//  i_reset    in   1      synchronous, active-high reset
//  i_ce       in   1      sample enable; all sample-domain actions occur only on i_ce
//  i_start    in   1      one-cycle pulse; starts a measurement when the block is idle
//  i_word     in   DW     normal data, passed through when idle
//  o_word     out  DW     registered output: passthrough, zeros, or the impulse
//  i_return   in   DW     return path sample
//  o_busy     out  1      high from the clock after an accepted start until DONE
//  o_valid    out  1      level; o_delay holds a good result
//  o_delay    out  LGDLY  measured latency d
//  o_fail     out  1      level; timeout (or mismatch, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; o_word, o_delay and the counter go to 0; o_busy, o_valid and o_fail go to 0.
//  States: IDLE -> QUIET -> FIRE -> LISTEN -> DONE -> IDLE.
//  - IDLE: on i_ce, o_word<=i_word. An i_start moves to QUIET on the next clock
//    (i_ce not needed), clears o_valid/o_fail and sets o_busy.
//  - QUIET: on i_ce, o_word<=0. The counter counts 2^LGDLY ce samples to flush
//    the path, then moves to FIRE.
//  - FIRE: on i_ce, o_word<=AMP, cnt<=1, then moves to LISTEN.
//  - LISTEN: on i_ce, o_word<=0.
//    - If i_return>=THRESH: o_delay<=cnt, o_valid<=1, move to DONE.
//    - Else if cnt==2^LGDLY-1: o_fail<=1, move to DONE.
//    - Else cnt<=cnt+1.
//  - DONE: clears o_busy and returns to IDLE on the next clock. o_valid and
//    o_fail hold until the next accepted i_start.
//  Latency definition: d = number of ce samples between o_word=AMP and the
//   detected i_return. A wire loopback (i_return=o_word) gives d=1. d=0 cannot
//   be measured.
//  Boundary conditions:
//  - i_start while busy is ignored.
//  - i_start and i_reset in the same cycle: reset wins.
//  - Reset mid-measurement aborts to IDLE; no result is posted.
//  - Detection at cnt=2^LGDLY-1 is a valid result, not a failure.
//  - No i_ce means no state progress except IDLE->QUIET and DONE->IDLE.
//  Width rules: cnt is LGDLY bits and never wraps. The comparison is signed and
//   DW bits wide.
// CONFIGURATION
//  DELAY_PROBE_CONFIRM_EN
//  - Defined: run two shots (QUIET/FIRE/LISTEN twice). Post o_valid only if
//    d1==d2. On mismatch, post o_fail=1 with o_delay=d1. A timeout on either
//    shot gives o_fail.
//  - Undefined: a single shot as described above.
// STRUCTURE
//  delay_probe_pkg:
//  - state encodings S_IDLE, S_QUIET, S_FIRE, S_LISTEN, S_DONE
//  - LGDLY-derived constants CNT_MAX and QUIET_LEN
//  Sub-module: delay_probe_ctr, an LGDLY-bit ce-gated counter with load-1,
//   increment and terminal-count flag. It is shared by QUIET and LISTEN.
// TESTING
//  1. Wire loopback, i_ce=1, i_start pulse -> o_delay=1, o_valid=1, o_fail=0.
//  2. Loopback through delayw (LGDLY=4, D=5), i_ce every 3rd clock -> o_delay=7
//     (D+2). Check o_busy timing.
//  3. i_return tied to 0 -> o_fail=1 after 2^LGDLY+2^LGDLY ce samples;
//     o_valid=0.
//  4. i_reset in mid-LISTEN, then i_start -> normal result. No stale o_valid
//     between the two.
//  5. i_start while busy and i_start at reset -> both ignored; IDLE
//     passthrough o_word==i_word (1 sample late).
//  6. With CONFIRM_EN, switch delayw D from 3 to 4 between shots -> o_fail=1,
//     o_delay=5.

Source files
------------

// File: rtl/delay_probe_pkg.sv
// Shared definitions for the delay_probe round-trip latency probe.
// State encodings, default span constants and helpers that derive the
// counter limits from a given LGDLY.
package delay_probe_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_QUIET  = 3'd1,
        S_FIRE   = 3'd2,
        S_LISTEN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int LGDLY_DEF = 5;
    // Largest measurable latency / terminal count of the shared counter.
    localparam int CNT_MAX   = (1 << LGDLY_DEF) - 1;
    // Number of ce samples of zeros used to flush the path before firing.
    localparam int QUIET_LEN = (1 << LGDLY_DEF);

    function automatic int cnt_max_of(input int lg);
        return (1 << lg) - 1;
    endfunction

    function automatic int quiet_len_of(input int lg);
        return (1 << lg);
    endfunction

endpackage

// File: rtl/delay_probe_ctr.sv
// LGDLY-bit ce-gated counter shared by the QUIET flush and the LISTEN
// latency count. Clear is not ce-gated so a start can zero it at once;
// load-1 and increment act only on i_ce. The count saturates at its
// terminal value and never wraps.
module delay_probe_ctr
    import delay_probe_pkg::*;
#(
    parameter int LGDLY = LGDLY_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_clear,
    input  logic             i_load1,
    input  logic             i_inc,
    output logic [LGDLY-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [LGDLY-1:0] CNT_TOP = LGDLY'(cnt_max_of(LGDLY));

    assign o_tc = (o_cnt == CNT_TOP);

    // Counter update: clear > load-1 > saturating increment.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cnt <= '0;
        end else if (i_clear) begin
            o_cnt <= '0;
        end else if (i_ce) begin
            if (i_load1)
                o_cnt <= LGDLY'(1);
            else if (i_inc && !o_tc)
                o_cnt <= o_cnt + LGDLY'(1);
        end
    end

endmodule

// File: rtl/delay_probe.sv
// delay_probe: measures round-trip latency of a DSP path in i_ce samples.
// Sends zeros for 2^LGDLY samples, fires one impulse of AMP, then counts
// samples until i_return >= THRESH (signed). Idle time passes i_word
// through to o_word one sample late.
// Optional build macro DELAY_PROBE_CONFIRM_EN: run two shots and only post
// a valid result when both agree; otherwise post o_fail with the first
// shot's delay.
//
// Handshake: i_start is a one-cycle pulse sampled every clock; it is
// accepted only in IDLE (ignored while busy, and lost if i_reset is high in
// the same cycle). o_busy rises the clock after acceptance and falls when
// the FSM leaves DONE; o_valid/o_fail are levels held until the next
// accepted start. o_state exposes the FSM state for observation.
module delay_probe
    import delay_probe_pkg::*;
#(
    parameter int LGDLY  = LGDLY_DEF,
    parameter int DW     = 12,
    parameter int AMP    = 2 ** (DW - 2),
    parameter int THRESH = 2 ** (DW - 3)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ce,
    input  logic             i_start,
    input  logic [DW-1:0]    i_word,
    output logic [DW-1:0]    o_word,
    input  logic [DW-1:0]    i_return,
    output logic             o_busy,
    output logic             o_valid,
    output logic [LGDLY-1:0] o_delay,
    output logic             o_fail,
    output logic [2:0]       o_state
);

    localparam logic signed [DW-1:0] AMP_W    = DW'(AMP);
    localparam logic signed [DW-1:0] THRESH_W = DW'(THRESH);

    state_t           state;
    logic [LGDLY-1:0] cnt;
    logic             tc;
    logic             detect;
    logic             ctr_clear;
    logic             ctr_load1;
    logic             ctr_inc;

`ifdef DELAY_PROBE_CONFIRM_EN
    logic             shot2;
    logic [LGDLY-1:0] d1;
`endif

    assign o_state = state;
    assign detect  = ($signed(i_return) >= THRESH_W);

    // Counter control: zero on an accepted start (and between shots),
    // load 1 on the FIRE sample, count during QUIET and LISTEN.
    always_comb begin
        ctr_clear = (state == S_IDLE) && i_start;
`ifdef DELAY_PROBE_CONFIRM_EN
        if ((state == S_LISTEN) && i_ce && detect && !shot2)
            ctr_clear = 1'b1;
`endif
        ctr_load1 = (state == S_FIRE);
        ctr_inc   = (state == S_QUIET) || ((state == S_LISTEN) && !detect);
    end

    delay_probe_ctr #(
        .LGDLY (LGDLY)
    ) u_ctr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_clear (ctr_clear),
        .i_load1 (ctr_load1),
        .i_inc   (ctr_inc),
        .o_cnt   (cnt),
        .o_tc    (tc)
    );

    // Measurement FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            o_word  <= '0;
            o_delay <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_fail  <= 1'b0;
`ifdef DELAY_PROBE_CONFIRM_EN
            shot2   <= 1'b0;
            d1      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_ce)
                        o_word <= i_word;
                    if (i_start) begin
                        state   <= S_QUIET;
                        o_valid <= 1'b0;
                        o_fail  <= 1'b0;
                        o_busy  <= 1'b1;
`ifdef DELAY_PROBE_CONFIRM_EN
                        shot2   <= 1'b0;
`endif
                    end
                end
                S_QUIET: begin
                    // Counter runs 0..CNT_MAX, i.e. 2^LGDLY flush samples.
                    if (i_ce) begin
                        o_word <= '0;
                        if (tc)
                            state <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    if (i_ce) begin
                        o_word <= AMP_W;
                        state  <= S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    if (i_ce) begin
                        o_word <= '0;
                        if (detect) begin
`ifdef DELAY_PROBE_CONFIRM_EN
                            if (!shot2) begin
                                d1    <= cnt;
                                shot2 <= 1'b1;
                                state <= S_QUIET;
                            end else begin
                                if (cnt == d1) begin
                                    o_delay <= cnt;
                                    o_valid <= 1'b1;
                                end else begin
                                    o_delay <= d1;
                                    o_fail  <= 1'b1;
                                end
                                state <= S_DONE;
                            end
`else
                            o_delay <= cnt;
                            o_valid <= 1'b1;
                            state   <= S_DONE;
`endif
                        end else if (tc) begin
                            o_fail <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_probe.sv
// Directed bench for delay_probe: loopback, ce-gated delay line, timeout,
// mid-measurement reset, ignored starts, passthrough and (with
// DELAY_PROBE_CONFIRM_EN) a two-shot mismatch.
module tb_delay_probe;
    import delay_probe_pkg::*;

    localparam int LGDLY = 5;
    localparam int DW    = 12;
`ifdef DELAY_PROBE_CONFIRM_EN
    localparam int SHOTS = 2;
`else
    localparam int SHOTS = 1;
`endif

    logic             i_clk = 1'b0;
    logic             i_reset;
    logic             i_ce;
    logic             i_start;
    logic [DW-1:0]    i_word;
    logic [DW-1:0]    o_word;
    logic [DW-1:0]    i_return;
    logic             o_busy;
    logic             o_valid;
    logic [LGDLY-1:0] o_delay;
    logic             o_fail;
    logic [2:0]       o_state;

    int checks   = 0;
    int failures = 0;

    int ce_mode  = 0;   // 0: every clock, 1: every 3rd clock, 2: off
    int phase    = 0;
    int ret_mode = 0;   // 0: wire loopback, 1: delay line, 2: tied to zero
    int dly_len  = 1;   // delay-line registers = D + 1

    logic [DW-1:0] dl [0:15] = '{default: '0};
    logic [DW-1:0] fire_word;
    logic [DW-1:0] listen_word;

    // Clock / reset
    always #5 i_clk = ~i_clk;

    delay_probe #(
        .LGDLY (LGDLY),
        .DW    (DW)
    ) dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .i_start  (i_start),
        .i_word   (i_word),
        .o_word   (o_word),
        .i_return (i_return),
        .o_busy   (o_busy),
        .o_valid  (o_valid),
        .o_delay  (o_delay),
        .o_fail   (o_fail),
        .o_state  (o_state)
    );

    // Return-path model: a ce-gated delayw-style register chain.
    always @(posedge i_clk) begin
        if (i_ce) begin
            dl[0] <= o_word;
            for (int i = 1; i < 16; i++)
                dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        case (ret_mode)
            0:       i_return = o_word;
            1:       i_return = dl[dly_len-1];
            default: i_return = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic set_ce();
        case (ce_mode)
            0: i_ce = 1'b1;
            1: begin
                i_ce  = (phase == 0);
                phase = (phase + 1) % 3;
            end
            default: i_ce = 1'b0;
        endcase
    endtask

    task automatic step();
        set_ce();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    // Pulses start, runs until o_busy falls; counts ce samples spent measuring.
    task automatic run_measure(input bit poke, input bit sw, output int n);
        bit to;
        bit poked;
        bit seen_listen;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("busy_rise", 32'(o_busy), 32'd1);
        check("valid_clr", 32'(o_valid), 32'd0);
        check("fail_clr", 32'(o_fail), 32'd0);
        n = 0;
        to = 1'b1;
        poked = 1'b0;
        seen_listen = 1'b0;
        fire_word = 'x;
        listen_word = 'x;
        for (int k = 0; k < 2000; k++) begin
            if (!o_busy) begin
                to = 1'b0;
                break;
            end
            if (o_state == S_FIRE)
                fire_word = o_word;
            if (o_state == S_LISTEN && !seen_listen) begin
                listen_word = o_word;
                seen_listen = 1'b1;
            end
            if (sw && seen_listen && o_state == S_QUIET)
                dly_len = 5;
            if (poke && o_state == S_LISTEN && !poked) begin
                i_start = 1'b1;
                poked = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            set_ce();
            if (i_ce && o_busy && !o_valid && !o_fail)
                n++;
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_start = 1'b0;
        check("timeout", 32'(to), 32'd0);
        check("idle_after", 32'(o_state), 32'(S_IDLE));
    endtask

    int n;

    initial begin
        i_reset = 1'b1;
        i_ce    = 1'b1;
        i_start = 1'b0;
        i_word  = 12'h5A5;
        @(negedge i_clk);
        step();
        step();
        check("rst_word", 32'(o_word), 32'd0);
        check("rst_delay", 32'(o_delay), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_fail", 32'(o_fail), 32'd0);
        check("rst_state", 32'(o_state), 32'(S_IDLE));
        i_reset = 1'b0;
        i_word  = '0;
        step();

        // 1. Wire loopback, ce every clock -> d=1
        ce_mode = 0; ret_mode = 0;
        run_measure(1'b0, 1'b0, n);
        check("t1_delay", 32'(o_delay), 32'd1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_fail", 32'(o_fail), 32'd0);
        check("t1_ce_cnt", 32'(n), 32'(SHOTS * 34));
        check("t1_fire_word", 32'(fire_word), 32'd0);
        check("t1_amp_word", 32'(listen_word), 32'h400);

        // 2. delayw D=5 (6 registers), ce every 3rd clock -> d=7
        ce_mode = 1; phase = 0; ret_mode = 1; dly_len = 6;
        run_measure(1'b0, 1'b0, n);
        check("t2_delay", 32'(o_delay), 32'd7);
        check("t2_valid", 32'(o_valid), 32'd1);
        check("t2_fail", 32'(o_fail), 32'd0);
        check("t2_ce_cnt", 32'(n), 32'(SHOTS * 40));

        // 3. Return tied to zero -> timeout after 64 samples; a start
        //    pulsed during LISTEN must not disturb it.
        ce_mode = 0; ret_mode = 2;
        run_measure(1'b1, 1'b0, n);
        check("t3_fail", 32'(o_fail), 32'd1);
        check("t3_valid", 32'(o_valid), 32'd0);
        check("t3_ce_cnt", 32'(n), 32'd64);

        // 4. Reset in mid-LISTEN aborts; then a normal measurement
        ce_mode = 0; ret_mode = 2;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 200 && o_state != S_LISTEN; k++)
            step();
        check("t4_reach_listen", 32'(o_state), 32'(S_LISTEN));
        step();
        step();
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        check("t4_abort_state", 32'(o_state), 32'(S_IDLE));
        check("t4_abort_busy", 32'(o_busy), 32'd0);
        check("t4_abort_valid", 32'(o_valid), 32'd0);
        check("t4_abort_fail", 32'(o_fail), 32'd0);
        check("t4_abort_delay", 32'(o_delay), 32'd0);
        ret_mode = 0;
        run_measure(1'b0, 1'b0, n);
        check("t4_delay", 32'(o_delay), 32'd1);
        check("t4_valid", 32'(o_valid), 32'd1);

        // 5. Start together with reset is ignored
        i_reset = 1'b1;
        i_start = 1'b1;
        step();
        i_reset = 1'b0;
        i_start = 1'b0;
        step();
        check("t5_rst_start_state", 32'(o_state), 32'(S_IDLE));
        check("t5_rst_start_busy", 32'(o_busy), 32'd0);
        check("t5_rst_start_valid", 32'(o_valid), 32'd0);

        // 5b. Passthrough, one sample late
        i_word = 12'h123;
        step();
        check("t5_pass_a", 32'(o_word), 32'h123);
        i_word = 12'hF00;
        step();
        check("t5_pass_b", 32'(o_word), 32'hF00);
        ce_mode = 2;
        i_word = 12'h0AA;
        step();
        check("t5_pass_hold", 32'(o_word), 32'hF00);

        // 5c. Without ce only IDLE->QUIET progresses
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 0; k < 10; k++)
            step();
        check("t5_noce_state", 32'(o_state), 32'(S_QUIET));
        check("t5_noce_busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0;
        ce_mode = 0;

`ifdef DELAY_PROBE_CONFIRM_EN
        // 6. Delay changes between shots (D=3 then D=4) -> fail with d1=5
        ce_mode = 0; ret_mode = 1; dly_len = 4;
        run_measure(1'b0, 1'b1, n);
        check("t6_fail", 32'(o_fail), 32'd1);
        check("t6_valid", 32'(o_valid), 32'd0);
        check("t6_delay", 32'(o_delay), 32'd5);
        check("t6_ce_cnt", 32'(n), 32'd77);
`endif

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
